regfile_ckpt: RTL and testbench
===============================

// Module: regfile_ckpt
// PURPOSE
//  Clocked, parametrised successor to the combinational GPR/EIP/EFLAGS update stage.
//  Holds NUM_REGS GPRs plus EIP and EFLAGS, and commits up to two register writes per step.
//  Adds one checkpoint slot for speculative-step rollback and a retired-step counter.
//  Sits after the ALU/opnd writeback stage; its outputs feed the next step's decode and operand fetch.
// PARAMETERS
//  WIDTH         32      data width of GPRs, EIP, EFLAGS
//  NUM_REGS      8       GPR count (EAX..EDI encoding order for 8)
//  SEL_W         3       selector width; must satisfy 2**SEL_W >= NUM_REGS
//  RESET_EIP     0       EIP value on reset
//  RESET_EFLAGS  32'h2   EFLAGS value on reset (reserved bit 1 set)
// PORTS
//  clk          in   1                 clock, rising edge
//  rst_n        in   1                 reset, asynchronous, active-low
//  en           in   1                 commit strobe: apply writes, EIP, EFLAGS this cycle
//  wr0_en       in   1                 write port 0 enable (priority port)
//  wr0_sel      in   SEL_W             write port 0 register select
//  wr0_data     in   WIDTH             write port 0 data
//  wr1_en       in   1                 write port 1 enable
//  wr1_sel      in   SEL_W             write port 1 register select
//  wr1_data     in   WIDTH             write port 1 data
//  next_eip     in   WIDTH             EIP to commit
//  next_eflags  in   WIDTH             EFLAGS to commit
//  ckpt_req     in   1                 capture a checkpoint of the current state
//  restore_req  in   1                 roll live state back to the checkpoint
//  rd0_sel      in   SEL_W             read port 0 select
//  rd0_data     out  WIDTH             read port 0 data, combinational from registered state
//  rd1_sel      in   SEL_W             read port 1 select
//  rd1_data     out  WIDTH             read port 1 data, combinational from registered state
//  gpr_flat     out  NUM_REGS*WIDTH    all GPRs, reg i at [i*WIDTH +: WIDTH]
//  eip          out  WIDTH             registered EIP
//  eflags       out  WIDTH             registered EFLAGS
//  retired      out  32                committed-step count, wraps 2**32-1 -> 0
//  ckpt_valid   out  1                 1 while FSM is in ARMED
//  restore_err  out  1                 one-cycle pulse: restore requested with no checkpoint
// BEHAVIOUR
//  - Reset (async, rst_n=0): GPRs=0, eip=RESET_EIP, eflags=RESET_EFLAGS, retired=0, FSM=IDLE,
//    ckpt_valid=0, restore_err=0. Checkpoint storage is cleared to the same values.
//  - FSM states IDLE/ARMED. ckpt_req: any state -> ARMED. Valid restore: ARMED -> IDLE.
//  - Commit (en=1, no restore this cycle): state updates on the same edge (1-cycle latency).
//    wr0 writes if wr0_en. wr1 writes if wr1_en and !(wr0_en && wr1_sel==wr0_sel), so port 0 wins a tie.
//    eip<=next_eip, eflags<=next_eflags, retired<=retired+1.
//  - Selectors >= NUM_REGS: write ignored; read returns 0.
//  - en=0: all live state holds. A wr*_en without en has no effect.
//  - ckpt_req: snapshot pre-edge GPRs/eip/eflags/retired. If en=1 in the same cycle, the commit
//    still happens and the snapshot holds the pre-commit values. ckpt_req while ARMED overwrites the slot.
//  - restore_req in ARMED: next edge loads all live state from the slot; en and writes ignored that
//    cycle; FSM -> IDLE.
//  - restore_req in IDLE: no state change (the commit proceeds if en=1); restore_err=1 for one cycle.
//  - ckpt_req and restore_req together: restore has priority (old slot used), ckpt_req dropped, FSM=IDLE.
//  - Reads have no write bypass: rd*_data shows the value written only from the cycle after the commit edge.
//  - rst_n asserted mid-sequence (incl. ARMED) discards the checkpoint immediately.
// TESTING
//  1. Reset release -> all GPR 0, eip=0, eflags=2, retired=0, ckpt_valid=0.
//  2. en, wr0 sel=1 data=5, wr1 sel=1 data=9 -> reg1=5 next cycle, retired=1.
//  3. ckpt_req with en and wr0 sel=0 data=AA -> reg0=AA; then restore_req -> reg0=0, eip and retired
//     restored, ckpt_valid=0.
//  4. restore_req in IDLE with en, next_eip=10 -> restore_err pulses 1 cycle, eip=10.
//  5. NUM_REGS=6: wr0 sel=7 data=FF -> no GPR changes; rd0_sel=7 -> 0.
//  6. retired preset via 2**32-1 commits (or forced) plus one more commit -> 0; rst_n low while ARMED
//     -> ckpt_valid 0 asynchronously.

Source files
------------

// File: rtl/regfile_ckpt.sv
// GPR/EIP/EFLAGS register file with dual-port commit, one rollback checkpoint and a retired-step counter.
// Commits land on the next edge; there is no backpressure, a step is accepted whenever en is high.
module regfile_ckpt #(
   parameter int               WIDTH        = 32,
   parameter int               NUM_REGS     = 8,
   parameter int               SEL_W        = 3,
   parameter logic [WIDTH-1:0] RESET_EIP    = '0,
   parameter logic [WIDTH-1:0] RESET_EFLAGS = WIDTH'(2)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      wr0_en,
   input  logic [SEL_W-1:0]          wr0_sel,
   input  logic [WIDTH-1:0]          wr0_data,
   input  logic                      wr1_en,
   input  logic [SEL_W-1:0]          wr1_sel,
   input  logic [WIDTH-1:0]          wr1_data,
   input  logic [WIDTH-1:0]          next_eip,
   input  logic [WIDTH-1:0]          next_eflags,
   input  logic                      ckpt_req,
   input  logic                      restore_req,
   input  logic [SEL_W-1:0]          rd0_sel,
   output logic [WIDTH-1:0]          rd0_data,
   input  logic [SEL_W-1:0]          rd1_sel,
   output logic [WIDTH-1:0]          rd1_data,
   output logic [NUM_REGS*WIDTH-1:0] gpr_flat,
   output logic [WIDTH-1:0]          eip,
   output logic [WIDTH-1:0]          eflags,
   output logic [31:0]               retired,
   output logic                      ckpt_valid,
   output logic                      restore_err
);

   typedef enum logic {IDLE, ARMED} state_t;

   state_t           state;
   logic [WIDTH-1:0] gpr    [NUM_REGS];
   logic [WIDTH-1:0] ck_gpr [NUM_REGS];
   logic [WIDTH-1:0] ck_eip;
   logic [WIDTH-1:0] ck_eflags;
   logic [31:0]      ck_ret;
   logic [31:0]      ret_cnt;
   logic             do_restore;

   assign do_restore = restore_req && (state == ARMED);
   assign retired    = ret_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            gpr[i]    <= '0;
            ck_gpr[i] <= '0;
         end
         eip         <= RESET_EIP;
         eflags      <= RESET_EFLAGS;
         ret_cnt     <= '0;
         ck_eip      <= RESET_EIP;
         ck_eflags   <= RESET_EFLAGS;
         ck_ret      <= '0;
         state       <= IDLE;
         ckpt_valid  <= 1'b0;
         restore_err <= 1'b0;
      end else begin
         restore_err <= restore_req && (state == IDLE);
         if (do_restore) begin
            // Rollback wins over everything else this cycle, including a fresh checkpoint.
            for (int i = 0; i < NUM_REGS; i++) begin
               gpr[i] <= ck_gpr[i];
            end
            eip        <= ck_eip;
            eflags     <= ck_eflags;
            ret_cnt    <= ck_ret;
            state      <= IDLE;
            ckpt_valid <= 1'b0;
         end else begin
            if (ckpt_req && !restore_req) begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  ck_gpr[i] <= gpr[i];
               end
               ck_eip     <= eip;
               ck_eflags  <= eflags;
               ck_ret     <= ret_cnt;
               state      <= ARMED;
               ckpt_valid <= 1'b1;
            end
            if (en) begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (wr0_en && (wr0_sel == SEL_W'(i))) begin
                     gpr[i] <= wr0_data;
                  end else if (wr1_en && (wr1_sel == SEL_W'(i))) begin
                     gpr[i] <= wr1_data;
                  end
               end
               eip     <= next_eip;
               eflags  <= next_eflags;
               ret_cnt <= ret_cnt + 32'd1;
            end
         end
      end
   end

   // Out-of-range selectors match no register and so read as zero.
   always_comb begin
      rd0_data = '0;
      rd1_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd0_sel == SEL_W'(i)) rd0_data = gpr[i];
         if (rd1_sel == SEL_W'(i)) rd1_data = gpr[i];
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign gpr_flat[g*WIDTH +: WIDTH] = gpr[g];
   end

endmodule

// File: tb/tb_regfile_ckpt.sv
// Bench for regfile_ckpt: an 8-register and a 6-register instance share stimulus and are
// compared against an array-based reference model, with directed cases followed by random steps.
module tb_regfile_ckpt;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en, wr0_en, wr1_en, ckpt_req, restore_req;
   logic [2:0]  wr0_sel, wr1_sel, rd0_sel, rd1_sel;
   logic [31:0] wr0_data, wr1_data, next_eip, next_eflags;

   logic [31:0]  rd0_8, rd1_8, eip8, efl8, ret8;
   logic [31:0]  rd0_6, rd1_6, eip6, efl6, ret6;
   logic [255:0] flat8;
   logic [191:0] flat6;
   logic         cv8, err8, cv6, err6;

   always #5 clk = ~clk;

   regfile_ckpt #(.NUM_REGS(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en),
      .wr0_en(wr0_en), .wr0_sel(wr0_sel), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_sel(wr1_sel), .wr1_data(wr1_data),
      .next_eip(next_eip), .next_eflags(next_eflags),
      .ckpt_req(ckpt_req), .restore_req(restore_req),
      .rd0_sel(rd0_sel), .rd0_data(rd0_8), .rd1_sel(rd1_sel), .rd1_data(rd1_8),
      .gpr_flat(flat8), .eip(eip8), .eflags(efl8), .retired(ret8),
      .ckpt_valid(cv8), .restore_err(err8));

   regfile_ckpt #(.NUM_REGS(6)) dut6 (
      .clk(clk), .rst_n(rst_n), .en(en),
      .wr0_en(wr0_en), .wr0_sel(wr0_sel), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_sel(wr1_sel), .wr1_data(wr1_data),
      .next_eip(next_eip), .next_eflags(next_eflags),
      .ckpt_req(ckpt_req), .restore_req(restore_req),
      .rd0_sel(rd0_sel), .rd0_data(rd0_6), .rd1_sel(rd1_sel), .rd1_data(rd1_6),
      .gpr_flat(flat6), .eip(eip6), .eflags(efl6), .retired(ret6),
      .ckpt_valid(cv6), .restore_err(err6));

   int checks = 0;
   int errors = 0;

   // Reference model: live state, one checkpoint slot, armed flag, expected error pulse.
   logic [31:0] m_gpr8 [8];
   logic [31:0] m_gpr6 [6];
   logic [31:0] c_gpr8 [8];
   logic [31:0] c_gpr6 [6];
   logic [31:0] m_eip, m_efl, m_ret, c_eip, c_efl, c_ret;
   bit          m_armed, m_err;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin m_gpr8[i] = '0; c_gpr8[i] = '0; end
      for (int i = 0; i < 6; i++) begin m_gpr6[i] = '0; c_gpr6[i] = '0; end
      m_eip = '0; m_efl = 32'h2; m_ret = '0;
      c_eip = '0; c_efl = 32'h2; c_ret = '0;
      m_armed = 0; m_err = 0;
   endtask

   task automatic model_update();
      int s0, s1;
      s0 = int'(wr0_sel);
      s1 = int'(wr1_sel);
      if (restore_req && m_armed) begin
         m_gpr8 = c_gpr8; m_gpr6 = c_gpr6;
         m_eip = c_eip; m_efl = c_efl; m_ret = c_ret;
         m_armed = 0; m_err = 0;
      end else begin
         m_err = restore_req;
         if (ckpt_req && !restore_req) begin
            c_gpr8 = m_gpr8; c_gpr6 = m_gpr6;
            c_eip = m_eip; c_efl = m_efl; c_ret = m_ret;
            m_armed = 1;
         end
         if (en) begin
            // Port 1 first, then port 0 on top, so port 0 wins any tie.
            if (wr1_en) m_gpr8[s1] = wr1_data;
            if (wr0_en) m_gpr8[s0] = wr0_data;
            if (wr1_en && s1 < 6) m_gpr6[s1] = wr1_data;
            if (wr0_en && s0 < 6) m_gpr6[s0] = wr0_data;
            m_eip = next_eip;
            m_efl = next_eflags;
            m_ret = m_ret + 1;
         end
      end
   endtask

   task automatic check_state(input string w);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s gpr8[%0d]", w, i), flat8[i*32 +: 32], m_gpr8[i]);
      for (int i = 0; i < 6; i++)
         check($sformatf("%s gpr6[%0d]", w, i), flat6[i*32 +: 32], m_gpr6[i]);
      check({w, " eip8"}, eip8, m_eip);
      check({w, " eip6"}, eip6, m_eip);
      check({w, " eflags8"}, efl8, m_efl);
      check({w, " eflags6"}, efl6, m_efl);
      check({w, " retired8"}, ret8, m_ret);
      check({w, " retired6"}, ret6, m_ret);
      check({w, " ckpt_valid8"}, cv8, m_armed);
      check({w, " ckpt_valid6"}, cv6, m_armed);
      check({w, " restore_err8"}, err8, m_err);
      check({w, " restore_err6"}, err6, m_err);
   endtask

   task automatic check_reads(input string w);
      int r0, r1;
      r0 = int'(rd0_sel);
      r1 = int'(rd1_sel);
      check({w, " rd0_8"}, rd0_8, m_gpr8[r0]);
      check({w, " rd1_8"}, rd1_8, m_gpr8[r1]);
      check({w, " rd0_6"}, rd0_6, (r0 < 6) ? m_gpr6[r0] : 32'h0);
      check({w, " rd1_6"}, rd1_6, (r1 < 6) ? m_gpr6[r1] : 32'h0);
   endtask

   task automatic drive(input logic e, input logic w0e, input logic [2:0] w0s, input logic [31:0] w0d,
                        input logic w1e, input logic [2:0] w1s, input logic [31:0] w1d,
                        input logic [31:0] ne, input logic [31:0] nf, input logic ck, input logic rs);
      en = e; wr0_en = w0e; wr0_sel = w0s; wr0_data = w0d;
      wr1_en = w1e; wr1_sel = w1s; wr1_data = w1d;
      next_eip = ne; next_eflags = nf; ckpt_req = ck; restore_req = rs;
   endtask

   // Called at a negedge with inputs already driven: check reads, take one edge, check state.
   task automatic step(input string w);
      #1 check_reads(w);
      @(posedge clk);
      #1;
      model_update();
      check_state(w);
      @(negedge clk);
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rd0_sel = 0; rd1_sel = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_state("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_state("after_reset");
      check("reset eflags", efl8, 32'h2);

      // Same-register tie: port 0 wins.
      rd0_sel = 1;
      drive(1, 1, 1, 32'h5, 1, 1, 32'h9, 32'h4, 32'h2, 0, 0);
      step("tie");
      check("tie reg1", flat8[63:32], 32'h5);
      check("tie retired", ret8, 32'h1);
      #1 check("tie rd0 after edge", rd0_8, 32'h5);

      // Checkpoint alongside a commit, then roll back (commit in the restore cycle is ignored).
      drive(1, 1, 0, 32'hAA, 0, 0, 0, 32'h8, 32'h2, 1, 0);
      step("ckpt");
      check("ckpt reg0", flat8[31:0], 32'hAA);
      check("ckpt valid", cv8, 1'b1);
      drive(1, 1, 0, 32'h55, 0, 0, 0, 32'hC, 32'h2, 0, 1);
      step("restore");
      check("restore reg0", flat8[31:0], 32'h0);
      check("restore eip", eip8, 32'h4);
      check("restore retired", ret8, 32'h1);
      check("restore valid", cv8, 1'b0);

      // Restore with no checkpoint: error pulse, commit still happens.
      drive(1, 0, 0, 0, 0, 0, 0, 32'd10, 32'h2, 0, 1);
      step("bad_restore");
      check("bad_restore err", err8, 1'b1);
      check("bad_restore eip", eip8, 32'd10);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("err_pulse");
      check("err pulse clears", err8, 1'b0);

      // Selector 7 is outside the 6-register instance.
      drive(1, 1, 7, 32'hFF, 0, 0, 0, 32'd14, 32'h2, 0, 0);
      step("oob");
      rd0_sel = 7;
      #1 check("oob rd0_6", rd0_6, 32'h0);
      check("oob rd0_8", rd0_8, 32'hFF);

      // Random stimulus.
      for (int n = 0; n < 500; n++) begin
         rd0_sel = 3'($urandom_range(0, 7));
         rd1_sel = 3'($urandom_range(0, 7));
         drive($urandom_range(0, 3) != 0,
               $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom,
               $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), $urandom,
               $urandom, $urandom,
               $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
         step($sformatf("rnd%0d", n));
      end

      // Retired counter wrap.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      force dut8.ret_cnt = 32'hFFFF_FFFF;
      force dut6.ret_cnt = 32'hFFFF_FFFF;
      #1;
      release dut8.ret_cnt;
      release dut6.ret_cnt;
      m_ret = 32'hFFFF_FFFF;
      #1 check("wrap preset", ret8, 32'hFFFF_FFFF);
      drive(1, 0, 0, 0, 0, 0, 0, 32'h20, 32'h2, 0, 0);
      step("wrap");
      check("wrap retired8", ret8, 32'h0);
      check("wrap retired6", ret6, 32'h0);

      // Asynchronous reset while armed.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("arm");
      check("arm valid", cv8, 1'b1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1 check("async ckpt_valid8", cv8, 1'b0);
      check("async ckpt_valid6", cv6, 1'b0);
      model_reset();
      check_state("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step("restore_after_reset");
      check("no ckpt after reset", err8, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
